// File: rtl/kernel_conv_engine.sv
// Sequential KxK convolution engine: unsigned pixel window times signed coefficient
// window, one tap per cycle, with wrap / signed-saturate / absolute-saturate output.
module kernel_conv_engine #(
  parameter int PIXEL_W = 4,
  parameter int COEF_W  = 5,
  parameter int K       = 3,
  parameter int OUT_W   = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       calc_enable,
  input  logic [1:0]                 mode,
  input  logic [K*K*PIXEL_W-1:0]     pixels,
  input  logic [K*K*COEF_W-1:0]      filter,
  output logic                       busy,
  output logic                       calc_done,
  output logic [OUT_W-1:0]           conv,
  output logic                       ovf
);

  localparam int TAPS  = K * K;
  localparam int ACC_W = PIXEL_W + COEF_W + $clog2(TAPS);
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MAC    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic signed [EXT_W-1:0] S_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] S_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] U_MAX = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [1:0]                 state;
  logic [TAP_W-1:0]           tap;
  logic signed [ACC_W-1:0]    acc;
  logic [TAPS*PIXEL_W-1:0]    pix_q;
  logic [TAPS*COEF_W-1:0]     coef_q;
  logic [1:0]                 mode_q;

  logic [PIXEL_W-1:0]         pix_sel;
  logic [COEF_W-1:0]          coef_sel;
  logic signed [ACC_W-1:0]    pix_ext;
  logic signed [ACC_W-1:0]    coef_ext;
  logic signed [ACC_W-1:0]    prod;
  logic                       last_tap;

  logic signed [EXT_W-1:0]    acc_x;
  logic signed [EXT_W-1:0]    mag;
  logic [OUT_W-1:0]           post_conv;
  logic                       post_ovf;

  assign busy     = (state == MAC) || (state == FINISH);
  assign last_tap = (tap == TAP_W'(TAPS - 1));

  // Operands are widened to the accumulator width first so the product is exact.
  always_comb begin
    pix_sel  = pix_q[int'(tap)*PIXEL_W +: PIXEL_W];
    coef_sel = coef_q[int'(tap)*COEF_W +: COEF_W];
    pix_ext  = {{(ACC_W-PIXEL_W){1'b0}}, pix_sel};
    coef_ext = {{(ACC_W-COEF_W){coef_sel[COEF_W-1]}}, coef_sel};
    prod     = pix_ext * coef_ext;
  end

  always_comb begin
    acc_x     = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc};
    mag       = acc_x[EXT_W-1] ? -acc_x : acc_x;
    post_conv = acc_x[OUT_W-1:0];
    post_ovf  = 1'b0;
    case (mode_q)
      2'b00: begin
        post_ovf = (acc_x > S_MAX) || (acc_x < S_MIN);
      end
      2'b10: begin
        if (mag > U_MAX) begin
          post_conv = U_MAX[OUT_W-1:0];
          post_ovf  = 1'b1;
        end else begin
          post_conv = mag[OUT_W-1:0];
        end
      end
      default: begin
        if (acc_x > S_MAX) begin
          post_conv = S_MAX[OUT_W-1:0];
          post_ovf  = 1'b1;
        end else if (acc_x < S_MIN) begin
          post_conv = S_MIN[OUT_W-1:0];
          post_ovf  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tap       <= '0;
      acc       <= '0;
      pix_q     <= '0;
      coef_q    <= '0;
      mode_q    <= '0;
      calc_done <= 1'b0;
      conv      <= '0;
      ovf       <= 1'b0;
    end else begin
      calc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (calc_enable) begin
            pix_q  <= pixels;
            coef_q <= filter;
            mode_q <= mode;
            acc    <= '0;
            tap    <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod;
          tap <= tap + TAP_W'(1);
          if (last_tap) state <= FINISH;
        end
        FINISH: begin
          conv      <= post_conv;
          ovf       <= post_ovf;
          calc_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
